dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder that answers the core's data-memory port (dmem write and read channels). It holds a word-addressed single-port SRAM array behind a small posted write buffer. Stores retire into the buffer immediately and drain to the array in cycles when no read uses the port. Loads return one cycle later, forwarded from the youngest matching buffered store when one exists.

## Interface
Parameters:
- ADDR_LEN, 32: address width in bits.
- DATA_LEN, 32: data width in bits. Word-only; no byte enables.
- MEM_WORDS, 1024: array depth in words. Must be a power of two; IDX = log2(MEM_WORDS).
- WB_DEPTH, 4: write-buffer entries. Must be a power of two, at least 2.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- dmem_we_i  in  1  store request this cycle.
- dmem_waddr_i  in  ADDR_LEN  store byte address.
- dmem_wdata_i  in  DATA_LEN  store data.
- dmem_re_i  in  1  load request this cycle.
- dmem_raddr_i  in  ADDR_LEN  load byte address.
- dmem_rdata_o  out  DATA_LEN  load data, registered.
- wb_count_o  out  log2(WB_DEPTH)+1  number of valid buffer entries.
- wb_full_o  out  1  asserted when wb_count_o == WB_DEPTH.
- wb_empty_o  out  1  asserted when wb_count_o == 0.
- overflow_o  out  1  sticky flag: a store was dropped.

## Operation
- Word index = addr[IDX+1:2]. Bits [1:0] are ignored (misaligned addresses are treated as aligned). Bits above IDX+1 are ignored, so out-of-range addresses alias into the array.
- The buffer is a circular FIFO with head and tail pointers of log2(WB_DEPTH) bits that wrap modulo WB_DEPTH. Each entry holds an index and data.
- Port arbitration: a load has priority for the single array port. Drain = !dmem_re_i && count != 0. Drain writes the head entry to the array and advances head.
- Store acceptance: accept = dmem_we_i && (count < WB_DEPTH || drain). An accepted store writes the tail entry and advances tail.
- Store dropped: dmem_we_i && full && dmem_re_i. The buffer is unchanged and overflow_o is set.
- Count update: count += accept − drain. A simultaneous accept and drain leaves count unchanged.
- Load lookup uses buffer and array state from before the current cycle's edge:
  - Compare the load index against all valid entries.
  - On one or more hits, return data from the entry closest to tail (youngest).
  - On no hit, return array[index].
  - A store presented in the same cycle as a load to the same index is not visible to that load.
- dmem_rdata_o updates only on cycles with dmem_re_i high. Otherwise it holds its previous value.
- overflow_o clears only on reset.
- Reset:
  - head, tail and count = 0; wb_empty_o = 1; wb_full_o = 0; overflow_o = 0; dmem_rdata_o = 0.
  - Array contents are not reset.
  - Any buffered stores are discarded, including when reset is asserted mid-drain; the array keeps only completed drains.

## Timing
- Load latency is 1 cycle: raddr is sampled at edge N and data is valid after edge N through edge N+1.
- Store-to-load visibility: a store accepted at edge N is readable by a load sampled at edge N+1 or later, via the forwarding path or the array.
- A drain at edge N makes the array hold the data after edge N. The same cycle's head advance removes the entry from forwarding, with no visibility gap.
- wb_count_o, wb_full_o and wb_empty_o are registered or derived from registered count, and reflect the state after each edge.
- Back-to-back loads starve the drain indefinitely. This is legal; stores are dropped only while full.
- Pointer wrap: after WB_DEPTH accepts, tail returns to 0. The youngest-match priority must follow age order, not raw slot position.

## Test plan
- Reset then idle: hold reset_i low 3 cycles, release → rdata 0, count 0, empty 1, full 0, overflow 0.
- Store then load: we to 0x40 with 0xDEADBEEF at edge 1, re 0x40 at edge 2 → rdata 0xDEADBEEF after edge 2. Repeat with re held continuously so the entry is still buffered → same data returned via forwarding.
- Youngest forwarding with wrap:
  - Pre-fill and drain 3 entries so tail sits at 3.
  - With re held high, store 0x100←1, 0x100←2, 0x100←3 (slots 3, 0, 1).
  - Load 0x100 → 3.
  - Drop re → count decrements 3,2,1,0 and array[0x40] = 3.
- Full boundary:
  - With re high, 4 stores → full 1.
  - 5th store with re high → dropped, overflow 1, count 4.
  - Store with re low → accepted with drain, count stays 4, overflow stays 1.
- Aliasing: store 0x0000_1004←0xA (MEM_WORDS=1024), load 0x0000_0006 → 0xA.
- Reset mid-operation: 3 buffered stores, assert reset_i mid-cycle → count 0 immediately. Loads of those addresses return prior array contents.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-memory port bundle between the core (master) and dmem_responder (slave).
// Carries the store channel, the load request and the registered load data.
interface dmem_responder_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    logic                dmem_we_i;
    logic [ADDR_LEN-1:0] dmem_waddr_i;
    logic [DATA_LEN-1:0] dmem_wdata_i;
    logic                dmem_re_i;
    logic [ADDR_LEN-1:0] dmem_raddr_i;
    logic [DATA_LEN-1:0] dmem_rdata_o;

    modport master (
        output dmem_we_i,
        output dmem_waddr_i,
        output dmem_wdata_i,
        output dmem_re_i,
        output dmem_raddr_i,
        input  dmem_rdata_o
    );

    modport slave (
        input  dmem_we_i,
        input  dmem_waddr_i,
        input  dmem_wdata_i,
        input  dmem_re_i,
        input  dmem_raddr_i,
        output dmem_rdata_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed single-port data memory fronted by a posted write buffer.
// Stores retire into the buffer and drain when no load owns the port; loads forward from the youngest match.
module dmem_responder #(
    parameter int ADDR_LEN  = 32,
    parameter int DATA_LEN  = 32,
    parameter int MEM_WORDS = 1024,
    parameter int WB_DEPTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    dmem_responder_if.slave           dmem,
    output logic [$clog2(WB_DEPTH):0] wb_count_o,
    output logic                      wb_full_o,
    output logic                      wb_empty_o,
    output logic                      overflow_o
);
    localparam int IDX   = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_LEN-1:0] mem     [MEM_WORDS];
    logic [IDX-1:0]      wb_idx  [WB_DEPTH];
    logic [DATA_LEN-1:0] wb_data [WB_DEPTH];

    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic                overflow;
    logic [DATA_LEN-1:0] rdata_q;

    logic [IDX-1:0]      widx;
    logic [IDX-1:0]      ridx;
    logic                full;
    logic                drain;
    logic                accept;
    logic                drop;
    logic                fwd_hit;
    logic [DATA_LEN-1:0] fwd_data;
    logic [PTR_W-1:0]    slot;
    logic                unused_addr_bits;

    // Out-of-range and sub-word address bits are deliberately ignored (aliasing).
    assign widx = dmem.dmem_waddr_i[IDX+1:2];
    assign ridx = dmem.dmem_raddr_i[IDX+1:2];
    assign unused_addr_bits = ^{dmem.dmem_waddr_i[ADDR_LEN-1:IDX+2], dmem.dmem_waddr_i[1:0],
                                dmem.dmem_raddr_i[ADDR_LEN-1:IDX+2], dmem.dmem_raddr_i[1:0]};

    assign full   = (count == CNT_W'(WB_DEPTH));
    assign drain  = !dmem.dmem_re_i && (count != '0);
    assign accept = dmem.dmem_we_i && (!full || drain);
    assign drop   = dmem.dmem_we_i && full && dmem.dmem_re_i;

    // Walk entries oldest to youngest so the last hit is the youngest, independent of slot position.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            slot = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && (wb_idx[slot] == ridx)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[slot];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            if (accept) begin
                tail <= tail + PTR_W'(1);
            end
            case ({accept, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            if (dmem.dmem_re_i) begin
                rdata_q <= fwd_hit ? fwd_data : mem[ridx];
            end
        end
    end

    // Buffer payload and array carry no reset; validity is defined purely by head/count.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            wb_idx[tail]  <= widx;
            wb_data[tail] <= dmem.dmem_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (drain) begin
            mem[wb_idx[head]] <= wb_data[head];
        end
    end

    assign dmem.dmem_rdata_o = rdata_q;
    assign wb_count_o        = count;
    assign wb_full_o         = full;
    assign wb_empty_o        = (count == '0);
    assign overflow_o        = overflow;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: reset, forwarding, wrap ordering,
// full/overflow boundary, address aliasing and mid-operation reset.
module tb_dmem_responder;
    logic        clk;
    logic        reset_n;
    logic [2:0]  wb_count;
    logic        wb_full;
    logic        wb_empty;
    logic        overflow;
    int          tests_run;
    int          tests_failed;

    dmem_responder_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

    dmem_responder #(
        .ADDR_LEN(32), .DATA_LEN(32), .MEM_WORDS(1024), .WB_DEPTH(4)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_n),
        .dmem       (bus),
        .wb_count_o (wb_count),
        .wb_full_o  (wb_full),
        .wb_empty_o (wb_empty),
        .overflow_o (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one cycle of inputs, then land 1 time unit after the rising edge.
    task automatic drive_cycle(input logic we, input logic [31:0] waddr, input logic [31:0] wdata,
                               input logic re, input logic [31:0] raddr);
        bus.dmem_we_i    = we;
        bus.dmem_waddr_i = waddr;
        bus.dmem_wdata_i = wdata;
        bus.dmem_re_i    = re;
        bus.dmem_raddr_i = raddr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.dmem_we_i = 1'b0;
        bus.dmem_re_i = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus.dmem_rdata_o !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL reset_rdata: got %h expected %h", bus.dmem_rdata_o, 32'h0);
        end
        tests_run++;
        if (wb_count !== 3'd0) begin
            tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", wb_count);
        end
        tests_run++;
        if (wb_empty !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL reset_empty: got %b expected 1", wb_empty);
        end
        tests_run++;
        if (wb_full !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL reset_full: got %b expected 0", wb_full);
        end
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow);
        end
    endtask

    task automatic test_store_load();
        drive_cycle(1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0);
        tests_run++;
        if (wb_count !== 3'd1) begin
            tests_failed++; $display("[TB] FAIL store_count: got %0d expected 1", wb_count);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'hDEADBEEF) begin
            tests_failed++; $display("[TB] FAIL store_load_next: got %h expected %h", bus.dmem_rdata_o, 32'hDEADBEEF);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tests_run++;
        if (wb_count !== 3'd0) begin
            tests_failed++; $display("[TB] FAIL store_drained: got %0d expected 0", wb_count);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'hDEADBEEF) begin
            tests_failed++; $display("[TB] FAIL load_from_array: got %h expected %h", bus.dmem_rdata_o, 32'hDEADBEEF);
        end
        // Same-edge store must be invisible to the load sampled on that edge.
        drive_cycle(1'b1, 32'h40, 32'h12345678, 1'b1, 32'h40);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'hDEADBEEF) begin
            tests_failed++; $display("[TB] FAIL same_cycle_hidden: got %h expected %h", bus.dmem_rdata_o, 32'hDEADBEEF);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'h12345678) begin
            tests_failed++; $display("[TB] FAIL forward_held_re: got %h expected %h", bus.dmem_rdata_o, 32'h12345678);
        end
        tests_run++;
        if (wb_count !== 3'd1) begin
            tests_failed++; $display("[TB] FAIL forward_still_buffered: got %0d expected 1", wb_count);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'h12345678) begin
            tests_failed++; $display("[TB] FAIL rdata_hold: got %h expected %h", bus.dmem_rdata_o, 32'h12345678);
        end
    endtask

    task automatic test_wrap_youngest();
        logic [2:0] exp_cnt [3];
        exp_cnt[0] = 3'd2; exp_cnt[1] = 3'd1; exp_cnt[2] = 3'd0;
        do_reset();
        drive_cycle(1'b1, 32'h200, 32'h1111, 1'b0, 32'h0);
        drive_cycle(1'b1, 32'h204, 32'h2222, 1'b0, 32'h0);
        drive_cycle(1'b1, 32'h208, 32'h3333, 1'b0, 32'h0);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tests_run++;
        if (wb_count !== 3'd0) begin
            tests_failed++; $display("[TB] FAIL wrap_prefill_drained: got %0d expected 0", wb_count);
        end
        for (int v = 1; v <= 3; v++) begin
            drive_cycle(1'b1, 32'h100, 32'(v), 1'b1, 32'h100);
        end
        tests_run++;
        if (wb_count !== 3'd3) begin
            tests_failed++; $display("[TB] FAIL wrap_count3: got %0d expected 3", wb_count);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'd3) begin
            tests_failed++; $display("[TB] FAIL wrap_youngest: got %h expected %h", bus.dmem_rdata_o, 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
            tests_run++;
            if (wb_count !== exp_cnt[i]) begin
                tests_failed++; $display("[TB] FAIL wrap_drain_%0d: got %0d expected %0d", i, wb_count, exp_cnt[i]);
            end
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'd3) begin
            tests_failed++; $display("[TB] FAIL wrap_array: got %h expected %h", bus.dmem_rdata_o, 32'd3);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h200);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'h1111) begin
            tests_failed++; $display("[TB] FAIL wrap_prefill_array: got %h expected %h", bus.dmem_rdata_o, 32'h1111);
        end
    endtask

    task automatic test_full_boundary();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 32'h10);
        end
        tests_run++;
        if (wb_full !== 1'b1 || wb_count !== 3'd4) begin
            tests_failed++; $display("[TB] FAIL full_after4: full=%b count=%0d expected full=1 count=4", wb_full, wb_count);
        end
        drive_cycle(1'b1, 32'h20, 32'hA4, 1'b1, 32'h10);
        tests_run++;
        if (overflow !== 1'b1 || wb_count !== 3'd4) begin
            tests_failed++; $display("[TB] FAIL full_drop: overflow=%b count=%0d expected overflow=1 count=4", overflow, wb_count);
        end
        drive_cycle(1'b1, 32'h24, 32'hA5, 1'b0, 32'h0);
        tests_run++;
        if (overflow !== 1'b1 || wb_count !== 3'd4) begin
            tests_failed++; $display("[TB] FAIL full_accept_drain: overflow=%b count=%0d expected overflow=1 count=4", overflow, wb_count);
        end
        repeat (4) drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tests_run++;
        if (wb_empty !== 1'b1 || wb_full !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL full_drained: empty=%b full=%b expected empty=1 full=0", wb_empty, wb_full);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h10);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'hA0) begin
            tests_failed++; $display("[TB] FAIL full_head_array: got %h expected %h", bus.dmem_rdata_o, 32'hA0);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h1C);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'hA3) begin
            tests_failed++; $display("[TB] FAIL full_last_array: got %h expected %h", bus.dmem_rdata_o, 32'hA3);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h24);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'hA5) begin
            tests_failed++; $display("[TB] FAIL full_late_store: got %h expected %h", bus.dmem_rdata_o, 32'hA5);
        end
    endtask

    task automatic test_aliasing();
        do_reset();
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL alias_overflow_cleared: got %b expected 0", overflow);
        end
        drive_cycle(1'b1, 32'h0000_1004, 32'hA, 1'b0, 32'h0);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0006);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'hA) begin
            tests_failed++; $display("[TB] FAIL alias_forward: got %h expected %h", bus.dmem_rdata_o, 32'hA);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0004);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'hA) begin
            tests_failed++; $display("[TB] FAIL alias_array: got %h expected %h", bus.dmem_rdata_o, 32'hA);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_cycle(1'b1, 32'h50, 32'h11, 1'b0, 32'h0);
        drive_cycle(1'b1, 32'h54, 32'h22, 1'b0, 32'h0);
        drive_cycle(1'b1, 32'h58, 32'h33, 1'b0, 32'h0);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        drive_cycle(1'b1, 32'h50, 32'h99, 1'b1, 32'h60);
        drive_cycle(1'b1, 32'h54, 32'h98, 1'b1, 32'h60);
        drive_cycle(1'b1, 32'h58, 32'h97, 1'b1, 32'h60);
        tests_run++;
        if (wb_count !== 3'd3) begin
            tests_failed++; $display("[TB] FAIL mid_buffered: got %0d expected 3", wb_count);
        end
        bus.dmem_we_i = 1'b0;
        bus.dmem_re_i = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (wb_count !== 3'd0 || wb_empty !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL mid_reset_async: count=%0d empty=%b expected count=0 empty=1", wb_count, wb_empty);
        end
        tests_run++;
        if (bus.dmem_rdata_o !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL mid_reset_rdata: got %h expected %h", bus.dmem_rdata_o, 32'h0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h50);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'h11) begin
            tests_failed++; $display("[TB] FAIL mid_discard_50: got %h expected %h", bus.dmem_rdata_o, 32'h11);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h54);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'h22) begin
            tests_failed++; $display("[TB] FAIL mid_discard_54: got %h expected %h", bus.dmem_rdata_o, 32'h22);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h58);
        tests_run++;
        if (bus.dmem_rdata_o !== 32'h33) begin
            tests_failed++; $display("[TB] FAIL mid_discard_58: got %h expected %h", bus.dmem_rdata_o, 32'h33);
        end
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        reset_n          = 1'b0;
        bus.dmem_we_i    = 1'b0;
        bus.dmem_waddr_i = '0;
        bus.dmem_wdata_i = '0;
        bus.dmem_re_i    = 1'b0;
        bus.dmem_raddr_i = '0;
        test_reset();
        test_store_load();
        test_wrap_youngest();
        test_full_boundary();
        test_aliasing();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
